// File: rtl/register_bank_writer.sv
// register_bank_writer
//   Write side of the 32 x 32-bit MIPS register file. A 5-bit destination
//   address is decoded into one-hot word enables. The write-back data is
//   captured into the addressed word on the rising clock edge. All words are
//   exported flat for the external 32:1 read muxes. Register 0 reads as zero.
//
// Ports
//   clk             : single clock, all state changes on the rising edge
//   reset           : synchronous, active-high; clears every register and status
//   write_en        : RegWrite; qualifies write_addr / write_data this cycle
//   write_addr      : destination register number
//   write_data      : write-back value
//   regs_flat       : register k on bits [32k+31:32k], k = 0..31
//   write_done      : one-cycle strobe, high the cycle after an accepted write
//   last_write_addr : address of the most recent accepted write
module register_bank_writer (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_en,
  input  logic [4:0]    write_addr,
  input  logic [31:0]   write_data,
  output logic [1023:0] regs_flat,
  output logic          write_done,
  output logic [4:0]    last_write_addr
);

  // Words 1..31 only. Register 0 has no storage, so it cannot ever load.
  logic [1023:32] bank;

  // Address 0 needs no enable because it has nothing to load.
  logic [31:1] we;

  // One-hot word enables, gated by write_en so X on the address is harmless when idle
  always_comb begin
    we = 31'h0000_0000;
    if (write_en == 1'b1) begin
      for (int k = 1; k < 32; k++) begin
        we[k] = (write_addr == 5'(k));
      end
    end else begin
      we = 31'h0000_0000;
    end
  end

  // Enable-gated word storage; reset takes priority over any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      bank <= {992{1'b0}};
    end else begin
      for (int k = 1; k < 32; k++) begin
        if (we[k]) begin
          bank[32*k +: 32] <= write_data;
        end
      end
    end
  end

  // Commit status: the strobe follows write_en, and the address holds while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      write_done      <= 1'b0;
      last_write_addr <= 5'd0;
    end else begin
      write_done <= write_en;
      if (write_en) begin
        last_write_addr <= write_addr;
      end else begin
        last_write_addr <= last_write_addr;
      end
    end
  end

  // No read latency: the flat view is the storage itself, with a hardwired zero word 0
  assign regs_flat = {bank, 32'h0000_0000};

endmodule

// File: tb/tb_register_bank_writer.sv
// tb_register_bank_writer
//   The driver applies one stimulus per cycle and pushes the state that the
//   array-based reference model expects after the next rising edge. The
//   monitor samples the DUT shortly after every rising edge. It pops one
//   expectation and compares all 32 words, write_done and last_write_addr.
module tb_register_bank_writer;

  logic          clk;
  logic          reset;
  logic          write_en;
  logic [4:0]    write_addr;
  logic [31:0]   write_data;
  logic [1023:0] regs_flat;
  logic          write_done;
  logic [4:0]    last_write_addr;

  register_bank_writer dut (
    .clk             (clk),
    .reset           (reset),
    .write_en        (write_en),
    .write_addr      (write_addr),
    .write_data      (write_data),
    .regs_flat       (regs_flat),
    .write_done      (write_done),
    .last_write_addr (last_write_addr)
  );

  typedef struct {
    logic [31:0] words [32];
    logic        done;
    logic [4:0]  addr;
  } exp_t;

  exp_t exp_q [$];

  // Reference model state
  logic [31:0] model_regs [32];
  logic        model_done;
  logic [4:0]  model_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_popped = 0;
  int n_pushed = 0;
  bit stim_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model by the rules of the register file, queue the expectation
  task automatic cycle(input logic rst, input logic we, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    reset      = rst;
    write_en   = we;
    write_addr = a;
    write_data = d;
    if (rst) begin
      foreach (model_regs[i]) model_regs[i] = 32'h0;
      model_done = 1'b0;
      model_addr = 5'd0;
    end else begin
      if (we && a != 5'd0) model_regs[a] = d;
      model_done = we;
      if (we) model_addr = a;
    end
    foreach (model_regs[i]) e.words[i] = model_regs[i];
    e.done = model_done;
    e.addr = model_addr;
    exp_q.push_back(e);
    n_pushed++;
    @(negedge clk);
  endtask

  // Monitor: compare the DUT's post-edge state against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_popped++;
        for (int k = 0; k < 32; k++) begin
          check($sformatf("word%0d", k), regs_flat[32*k +: 32], e.words[k]);
        end
        check("write_done", {31'h0, write_done}, {31'h0, e.done});
        check("last_write_addr", {27'h0, last_write_addr}, {27'h0, e.addr});
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: stimulus did not complete, popped %0d of %0d", n_popped, n_pushed);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    foreach (model_regs[i]) model_regs[i] = 32'h0;
    model_done = 1'b0;
    model_addr = 5'd0;

    // Reset for two cycles, then idle with don't-care address/data
    cycle(1'b1, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 5'bx, 32'hxxxx_xxxx);

    // Single write followed by an idle cycle
    cycle(1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b0, 5'd0, 32'h0);

    // Write to the hardwired zero register
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 5'd0, 32'h0);

    // Walking write, back to back
    for (int k = 1; k < 32; k++) cycle(1'b0, 1'b1, 5'(k), 32'h1000_0000 + 32'(k));
    cycle(1'b0, 1'b0, 5'd0, 32'h0);

    // Overwrite and gating
    cycle(1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5);
    cycle(1'b0, 1'b1, 5'd31, 32'h5A5A_5A5A);
    cycle(1'b0, 1'b0, 5'd31, 32'h0);

    // Fill, then reset colliding with a write
    for (int k = 1; k < 32; k++) cycle(1'b0, 1'b1, 5'(k), $urandom());
    cycle(1'b1, 1'b1, 5'd3, 32'h1234_5678);
    cycle(1'b0, 1'b0, 5'd0, 32'h0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic w;
      r = ($urandom_range(0, 39) == 0);
      w = ($urandom_range(0, 3) != 0);
      cycle(r, w, 5'($urandom_range(0, 31)), $urandom());
    end
    cycle(1'b0, 1'b0, 5'd0, 32'h0);

    // Let the monitor drain the last expectation
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    check("popped_count", 32'(n_popped), 32'(n_pushed));
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank_writer.md
# register_bank_writer

Write side of the 32 x 32-bit MIPS register file. It decodes a 5-bit write address into 32 one-hot word enables and captures write-back data into the addressed register on the clock edge. All 32 registers are exported flat so the per-bit 32:1 read-selection muxes can pick operands. Register 0 is hardwired to zero, and a registered write-done strobe lets the datapath and bench confirm each commit.

## Interface
- Parameters: none. Widths are fixed at 32 registers x 32 bits.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is sampled high.
- write_en  input  1  RegWrite from control; qualifies write_addr/write_data this cycle.
- write_addr  input  5  destination register number (rd or rt after RegDst selection).
- write_data  input  32  write-back value (ALU result or memory data after MemtoReg selection).
- regs_flat  output  1024  register k appears on bits [32k+31:32k]; k = 0..31.
- write_done  output  1  one-cycle pulse, asserted the cycle after an accepted write.
- last_write_addr  output  5  address of the most recent accepted write.

## Operation
- Decoder: 5-to-32 one-hot decode of write_addr, ANDed with write_en, gives word enables we[31:0]. At most one enable is high.
- Storage: 32 words of 32 enable-gated flip-flops. Word k loads write_data when we[k]=1 and otherwise holds its value.
- Register 0: never loads. regs_flat[31:0] is constant 0 at all times, including after any write to address 0.
- Accepted write: any cycle with write_en=1 and reset=0, including address 0. Each accepted write sets write_done=1 and last_write_addr=write_addr on the next edge.
- write_en=0: no register changes. write_done=0 next cycle. last_write_addr holds.
- Reset: all 32 registers become 0, write_done=0, last_write_addr=0.
- Reset during a write: reset wins. The write is dropped, and write_done stays 0 on the following cycle.
- write_addr and write_data are don't-care when write_en=0. X on them must not corrupt any register.
- No read ports. Reading is combinational through the external 32:1 muxes on regs_flat, and this block adds no read latency.

## Timing
- Write latency: data presented at edge N is visible on regs_flat immediately after edge N (registered output, no extra stage).
- write_done and last_write_addr update on the same edge N as the register, so write_done is high during cycle N+1.
- Back-to-back writes, one per cycle, are supported. write_done stays high continuously, and last_write_addr tracks each write.
- Same address written on consecutive cycles: the later value wins, and there is no merge.
- Read-during-write: a combinational reader in the same cycle sees the old value. There is no internal bypass; forwarding is the datapath's responsibility.
- Reset values: regs_flat = 1024'h0, write_done = 0, last_write_addr = 5'd0.

## Test plan
- Reset then idle: assert reset for 2 cycles, then hold write_en=0 for 5 cycles. Required: regs_flat == 0, write_done == 0 and last_write_addr == 0 throughout.
- Single write: write_en=1, write_addr=5'd8, write_data=32'hDEADBEEF for one cycle. Next cycle: regs_flat[287:256]=32'hDEADBEEF, every other word 0, write_done=1, last_write_addr=8. The cycle after: write_done=0.
- Zero register: write addr 0 with data 32'hFFFFFFFF. Required: regs_flat[31:0] stays 0, write_done=1, last_write_addr=0.
- Walking write: write addr k with data 32'h1000_0000+k for k = 1..31 on consecutive cycles. Required: each word k matches its value, and write_done stays high for 31 cycles.
- Overwrite and gating:
  - Write addr 31 with 32'hA5A5A5A5, then with 32'h5A5A5A5A. Required: word 31 = 32'h5A5A5A5A.
  - Then drive addr 31, data 32'h0 with write_en=0. Required: word 31 unchanged, write_done=0.
- Reset mid-operation:
  - Fill regs 1..31, then assert reset in the same cycle as a write to addr 3 with 32'h12345678. Required: next cycle all words 0, write_done=0, last_write_addr=0.
